// File: rtl/uninasoc_plic_core_if.sv
// MEM-protocol bus between a requester and the PLIC core register file.
// Handshake: gnt mirrors req in the same cycle; every granted request gets exactly one
// response cycle (valid=1) on the next clock with rdata/error; there is no backpressure.
interface uninasoc_plic_core_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    valid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    error;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, valid, rdata, error
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, valid, rdata, error
    );
endinterface

// File: rtl/uninasoc_plic_core.sv
// RISC-V PLIC core: per-source gateways, priority/enable/threshold arbitration per target,
// claim/complete, all behind a MEM slave port with error reporting.
module uninasoc_plic_core #(
    parameter int                    SOURCE_NUM      = 32,
    parameter int                    TARGET_NUM      = 1,
    parameter int                    PRIO_WIDTH      = 3,
    parameter logic [SOURCE_NUM-1:0] LEVEL_EDGE_TRIG = '0,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    SRCW            = $clog2(SOURCE_NUM)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [SOURCE_NUM-1:0]                intr_src_i,
    output logic [TARGET_NUM-1:0]                irq_o,
    output logic [TARGET_NUM-1:0][SRCW-1:0]      irq_id_o,
    output logic [SOURCE_NUM-1:0][1:0]           dbg_gw_state,
    uninasoc_plic_core_if.slave                  s_mem
);

    localparam int NW = (SOURCE_NUM + 31) / 32;

    typedef enum logic [1:0] {
        GW_IDLE       = 2'd0,
        GW_PENDING    = 2'd1,
        GW_IN_SERVICE = 2'd2
    } gw_state_e;

    gw_state_e               gw_q [SOURCE_NUM];
    gw_state_e               gw_d [SOURCE_NUM];
    logic [SOURCE_NUM-1:0]   latch_q, latch_d;
    logic [SOURCE_NUM-1:0]   src_q;
    logic [SOURCE_NUM-1:0]   src_edge, gw_set, pending;

    logic [PRIO_WIDTH-1:0]   prio_q [SOURCE_NUM];
    logic [PRIO_WIDTH-1:0]   prio_d [SOURCE_NUM];
    logic [SOURCE_NUM-1:0]   en_q   [TARGET_NUM];
    logic [SOURCE_NUM-1:0]   en_d   [TARGET_NUM];
    logic [PRIO_WIDTH-1:0]   thr_q  [TARGET_NUM];
    logic [PRIO_WIDTH-1:0]   thr_d  [TARGET_NUM];

    logic [SRCW-1:0]         win_id     [TARGET_NUM];
    logic [PRIO_WIDTH-1:0]   best_prio  [TARGET_NUM];
    logic [TARGET_NUM-1:0]   win_valid;

    logic [ADDR_WIDTH-1:0]   addr;
    logic [25:0]             off;
    int                      word, en_t, en_w, ctx_t, cmp_id;
    logic                    is_prio, is_pend, is_en, is_thr, is_claim;
    logic                    bus_err, rd_ok, wr_ok;
    logic [SOURCE_NUM-1:0]   claim_vec, complete_vec;
    logic [DATA_WIDTH-1:0]   rdata_d, rdata_q;
    logic                    valid_q, error_q;
    logic                    unused_ok;

    assign addr      = s_mem.addr;
    assign off       = addr[25:0];
    assign unused_ok = ^{addr, s_mem.wdata};

    assign s_mem.gnt   = s_mem.req;
    assign s_mem.valid = valid_q;
    assign s_mem.rdata = rdata_q;
    assign s_mem.error = error_q;

    always_comb begin
        for (int s = 0; s < SOURCE_NUM; s++) begin
            pending[s]      = (gw_q[s] == GW_PENDING);
            dbg_gw_state[s] = gw_q[s];
        end
    end

    // Edge sources compare against last cycle's sample; level sources request while high.
    assign src_edge = intr_src_i & ~src_q & LEVEL_EDGE_TRIG;
    assign gw_set   = src_edge | (intr_src_i & ~LEVEL_EDGE_TRIG);

    // Address decode
    always_comb begin
        word     = int'(off[11:2]);
        en_t     = int'(off[11:7]);
        en_w     = int'(off[6:2]);
        ctx_t    = int'(off[20:12]);
        cmp_id   = int'(s_mem.wdata[SRCW-1:0]);
        is_prio  = (off[25:12] == 14'd0) && (word < SOURCE_NUM);
        is_pend  = (off[25:12] == 14'd1) && (word < NW);
        is_en    = (off[25:12] == 14'd2) && (en_t < TARGET_NUM) && (en_w < NW);
        is_thr   = (off[25:21] == 5'd1) && (ctx_t < TARGET_NUM) && (off[11:0] == 12'h000);
        is_claim = (off[25:21] == 5'd1) && (ctx_t < TARGET_NUM) && (off[11:0] == 12'h004);
        bus_err  = (off[1:0] != 2'b00)
                 || !(is_prio || is_pend || is_en || is_thr || is_claim)
                 || (s_mem.we && !(&s_mem.be));
        rd_ok    = s_mem.req && !s_mem.we && !bus_err;
        wr_ok    = s_mem.req &&  s_mem.we && !bus_err;
    end

    // Per-target arbitration: strict '>' keeps the lowest ID on equal priority.
    always_comb begin
        for (int t = 0; t < TARGET_NUM; t++) begin
            best_prio[t] = '0;
            win_id[t]    = '0;
            win_valid[t] = 1'b0;
            for (int s = 1; s < SOURCE_NUM; s++) begin
                if (pending[s] && en_q[t][s] && (prio_q[s] > thr_q[t]) && (prio_q[s] > best_prio[t])) begin
                    best_prio[t] = prio_q[s];
                    win_id[t]    = SRCW'(s);
                    win_valid[t] = 1'b1;
                end
            end
        end
    end

    // Register reads/writes, claim and complete
    always_comb begin
        prio_d       = prio_q;
        en_d         = en_q;
        thr_d        = thr_q;
        claim_vec    = '0;
        complete_vec = '0;
        rdata_d      = '0;
        if (rd_ok) begin
            for (int s = 0; s < SOURCE_NUM; s++) begin
                if (is_prio && s == word) rdata_d = DATA_WIDTH'(prio_q[s]);
                if (is_pend && (s / 32) == word) rdata_d[s % 32] = pending[s];
            end
            for (int t = 0; t < TARGET_NUM; t++) begin
                if (t == ctx_t && is_thr) rdata_d = DATA_WIDTH'(thr_q[t]);
                if (t == ctx_t && is_claim) begin
                    rdata_d = DATA_WIDTH'(win_id[t]);
                    for (int s = 1; s < SOURCE_NUM; s++) begin
                        if (win_valid[t] && win_id[t] == SRCW'(s)) claim_vec[s] = 1'b1;
                    end
                end
                for (int s = 0; s < SOURCE_NUM; s++) begin
                    if (is_en && t == en_t && (s / 32) == en_w) rdata_d[s % 32] = en_q[t][s];
                end
            end
        end
        if (wr_ok) begin
            for (int s = 1; s < SOURCE_NUM; s++) begin
                if (is_prio && s == word) prio_d[s] = s_mem.wdata[PRIO_WIDTH-1:0];
            end
            for (int t = 0; t < TARGET_NUM; t++) begin
                if (is_thr && t == ctx_t) thr_d[t] = s_mem.wdata[PRIO_WIDTH-1:0];
                for (int s = 1; s < SOURCE_NUM; s++) begin
                    if (is_en && t == en_t && (s / 32) == en_w) en_d[t][s] = s_mem.wdata[s % 32];
                    if (is_claim && t == ctx_t && s == cmp_id && en_q[t][s] && gw_q[s] == GW_IN_SERVICE)
                        complete_vec[s] = 1'b1;
                end
            end
        end
    end

    // Gateway next state; an edge while busy is remembered once and replayed on complete.
    always_comb begin
        gw_d    = gw_q;
        latch_d = latch_q;
        for (int s = 1; s < SOURCE_NUM; s++) begin
            case (gw_q[s])
                GW_IDLE: begin
                    if (gw_set[s]) gw_d[s] = GW_PENDING;
                end
                GW_PENDING: begin
                    if (claim_vec[s]) gw_d[s] = GW_IN_SERVICE;
                    if (src_edge[s])  latch_d[s] = 1'b1;
                end
                GW_IN_SERVICE: begin
                    if (complete_vec[s]) begin
                        if (latch_q[s] || src_edge[s]) begin
                            gw_d[s]    = GW_PENDING;
                            latch_d[s] = 1'b0;
                        end else begin
                            gw_d[s] = GW_IDLE;
                        end
                    end else if (src_edge[s]) begin
                        latch_d[s] = 1'b1;
                    end
                end
                default: gw_d[s] = GW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SOURCE_NUM; s++) begin
                gw_q[s]   <= GW_IDLE;
                prio_q[s] <= '0;
            end
            for (int t = 0; t < TARGET_NUM; t++) begin
                en_q[t]  <= '0;
                thr_q[t] <= '0;
            end
            latch_q  <= '0;
            src_q    <= '0;
            irq_o    <= '0;
            irq_id_o <= '0;
            valid_q  <= 1'b0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            gw_q     <= gw_d;
            prio_q   <= prio_d;
            en_q     <= en_d;
            thr_q    <= thr_d;
            latch_q  <= latch_d;
            src_q    <= intr_src_i;
            for (int t = 0; t < TARGET_NUM; t++) begin
                irq_o[t]    <= win_valid[t];
                irq_id_o[t] <= win_id[t];
            end
            valid_q  <= s_mem.req;
            rdata_q  <= rdata_d;
            error_q  <= s_mem.req && bus_err;
        end
    end

endmodule

// File: tb/tb_uninasoc_plic_core.sv
// Directed bench for uninasoc_plic_core: two targets, source 4 edge-triggered, rest level.
module tb_uninasoc_plic_core;
    localparam int SN   = 32;
    localparam int TN   = 2;
    localparam int SRCW = 5;
    localparam logic [SN-1:0] EDGE_SRCS = 32'h0000_0010;

    localparam logic [31:0] PEND   = 32'h0000_1000;
    localparam logic [31:0] EN0    = 32'h0000_2000;
    localparam logic [31:0] EN1    = 32'h0000_2080;
    localparam logic [31:0] THR0   = 32'h0020_0000;
    localparam logic [31:0] CLAIM0 = 32'h0020_0004;
    localparam logic [31:0] CLAIM1 = 32'h0020_1004;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [SN-1:0]            src;
    logic [TN-1:0]            irq;
    logic [TN-1:0][SRCW-1:0]  irq_id;
    logic [SN-1:0][1:0]       gw_state;
    int                       n_checks = 0;
    int                       n_fail   = 0;
    logic [31:0]              exp_q[$];
    logic [31:0]              exp_id;
    logic [31:0]              r;
    logic                     e;

    uninasoc_plic_core_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_mem ();

    uninasoc_plic_core #(
        .SOURCE_NUM(SN), .TARGET_NUM(TN), .PRIO_WIDTH(3),
        .LEVEL_EDGE_TRIG(EDGE_SRCS), .ADDR_WIDTH(32), .DATA_WIDTH(32)
    ) dut (
        .clk_i(clk), .rst_i(rst), .intr_src_i(src), .irq_o(irq),
        .irq_id_o(irq_id), .dbg_gw_state(gw_state), .s_mem(s_mem)
    );

    // Clock and time limit
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] a_prio(input int id);
        return 32'(4 * id);
    endfunction

    // Driver: one request, response expected on the following clock.
    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        s_mem.req   = 1'b1;
        s_mem.we    = we;
        s_mem.addr  = addr;
        s_mem.wdata = wdata;
        s_mem.be    = be;
        #1 check("gnt", 64'(s_mem.gnt), 64'd1);
        @(negedge clk);
        s_mem.req = 1'b0;
        s_mem.we  = 1'b0;
        check("valid", 64'(s_mem.valid), 64'd1);
        rdata = s_mem.rdata;
        err   = s_mem.error;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rr;
        logic        ee;
        bus(1'b1, addr, data, 4'hF, rr, ee);
        check("wr_err", 64'(ee), 64'd0);
        check("wr_rdata", 64'(rr), 64'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rr;
        logic        ee;
        bus(1'b0, addr, 32'd0, 4'hF, rr, ee);
        check(tag, 64'(rr), 64'(exp));
        check({tag, "_err"}, 64'(ee), 64'd0);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        src         = '0;
        s_mem.req   = 1'b0;
        s_mem.we    = 1'b0;
        s_mem.addr  = '0;
        s_mem.wdata = '0;
        s_mem.be    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_irq_id", 64'(irq_id), 64'd0);
        check("rst_valid", 64'(s_mem.valid), 64'd0);
        check("rst_rdata", 64'(s_mem.rdata), 64'd0);
        check("rst_error", 64'(s_mem.error), 64'd0);
        check("rst_gw", 64'(gw_state), 64'd0);

        // Level source 5
        wr(a_prio(5), 32'd3);
        wr(EN0, 32'h0000_0020);
        wr(THR0, 32'd0);
        @(negedge clk);
        src[5] = 1'b1;
        repeat (2) @(negedge clk);
        check("l5_irq", 64'(irq), 64'b01);
        check("l5_id", 64'(irq_id[0]), 64'd5);
        rd_chk("l5_claim", CLAIM0, 32'd5);
        @(negedge clk);
        check("l5_irq_claimed", 64'(irq[0]), 64'd0);
        check("l5_gw_insvc", 64'(gw_state[5]), 64'd2);
        wr(CLAIM0, 32'd5);
        settle();
        check("l5_reassert", 64'(irq[0]), 64'd1);
        check("l5_reassert_id", 64'(irq_id[0]), 64'd5);
        @(negedge clk);
        src[5] = 1'b0;
        rd_chk("l5_claim2", CLAIM0, 32'd5);
        wr(CLAIM0, 32'd5);
        settle();
        check("l5_idle", 64'(gw_state[5]), 64'd0);

        // Priority ordering with sticky level sources 3, 7, 9
        wr(a_prio(3), 32'd2);
        wr(a_prio(7), 32'd2);
        wr(a_prio(9), 32'd1);
        wr(EN0, 32'h0000_0288);
        @(negedge clk);
        src[3] = 1'b1; src[7] = 1'b1; src[9] = 1'b1;
        @(negedge clk);
        src[3] = 1'b0; src[7] = 1'b0; src[9] = 1'b0;
        settle();
        rd_chk("arb_pending", PEND, 32'h0000_0288);
        check("arb_id", 64'(irq_id[0]), 64'd3);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd9);
        exp_q.push_back(32'd0);
        while (exp_q.size() > 0) begin
            exp_id = exp_q.pop_front();
            rd_chk("arb_claim", CLAIM0, exp_id);
        end
        wr(CLAIM0, 32'd3);
        wr(CLAIM0, 32'd7);
        wr(CLAIM0, 32'd9);
        settle();
        check("arb_idle9", 64'(gw_state[9]), 64'd0);
        wr(THR0, 32'd2);
        @(negedge clk);
        src[9] = 1'b1;
        settle();
        check("thr_irq", 64'(irq[0]), 64'd0);
        check("thr_id", 64'(irq_id[0]), 64'd0);
        rd_chk("thr_pending", PEND, 32'h0000_0200);
        rd_chk("thr_claim_none", CLAIM0, 32'd0);
        wr(THR0, 32'd0);
        settle();
        check("thr_low_irq", 64'(irq[0]), 64'd1);
        check("thr_low_id", 64'(irq_id[0]), 64'd9);
        @(negedge clk);
        src[9] = 1'b0;
        rd_chk("thr_claim9", CLAIM0, 32'd9);
        wr(CLAIM0, 32'd9);
        settle();
        check("thr_idle9", 64'(gw_state[9]), 64'd0);

        // Edge source 4 with one-deep latch
        wr(a_prio(4), 32'd2);
        wr(EN0, 32'h0000_0010);
        @(negedge clk); src[4] = 1'b1;
        @(negedge clk); src[4] = 1'b0;
        settle();
        check("edge_irq", 64'(irq[0]), 64'd1);
        check("edge_id", 64'(irq_id[0]), 64'd4);
        rd_chk("edge_claim", CLAIM0, 32'd4);
        @(negedge clk); src[4] = 1'b1;
        @(negedge clk); src[4] = 1'b0;
        @(negedge clk); src[4] = 1'b1;
        @(negedge clk); src[4] = 1'b0;
        settle();
        check("edge_insvc_irq", 64'(irq[0]), 64'd0);
        check("edge_insvc_gw", 64'(gw_state[4]), 64'd2);
        rd_chk("edge_insvc_pend", PEND, 32'd0);
        wr(CLAIM0, 32'd4);
        settle();
        rd_chk("edge_replay_pend", PEND, 32'h0000_0010);
        check("edge_replay_gw", 64'(gw_state[4]), 64'd1);
        rd_chk("edge_claim2", CLAIM0, 32'd4);
        wr(CLAIM0, 32'd4);
        settle();
        rd_chk("edge_claim3", CLAIM0, 32'd0);
        check("edge_idle", 64'(gw_state[4]), 64'd0);

        // Bus errors and register field behaviour
        bus(1'b1, 32'h000F_0000, 32'd5, 4'hF, r, e);
        check("err_unmapped", 64'(e), 64'd1);
        check("err_unmapped_rdata", 64'(r), 64'd0);
        bus(1'b1, a_prio(4), 32'd7, 4'h3, r, e);
        check("err_partial_be", 64'(e), 64'd1);
        rd_chk("err_prio_kept", a_prio(4), 32'd2);
        bus(1'b0, a_prio(4) + 32'd2, 32'd0, 4'hF, r, e);
        check("err_misaligned", 64'(e), 64'd1);
        bus(1'b0, 32'h0000_2100, 32'd0, 4'hF, r, e);
        check("err_en_target2", 64'(e), 64'd1);
        wr(PEND, 32'hFFFF_FFFF);
        rd_chk("pend_ro", PEND, 32'd0);
        wr(a_prio(0), 32'd7);
        rd_chk("prio0_zero", a_prio(0), 32'd0);
        wr(a_prio(10), 32'hFFFF_FFFF);
        rd_chk("prio_trunc", a_prio(10), 32'd7);
        wr(a_prio(10), 32'd0);
        wr(EN0, 32'hFFFF_FFFF);
        rd_chk("en_bit0", EN0, 32'hFFFF_FFFE);
        wr(EN0, 32'd0);

        // Second target
        wr(a_prio(6), 32'd1);
        wr(EN1, 32'h0000_0040);
        @(negedge clk);
        src[6] = 1'b1;
        settle();
        check("t1_irq", 64'(irq), 64'b10);
        check("t1_id1", 64'(irq_id[1]), 64'd6);
        check("t1_id0", 64'(irq_id[0]), 64'd0);
        rd_chk("t1_claim", CLAIM1, 32'd6);
        @(negedge clk);
        src[6] = 1'b0;
        settle();
        check("t1_irq_off", 64'(irq), 64'b00);
        wr(CLAIM0, 32'd6);
        settle();
        check("t1_wrong_complete", 64'(gw_state[6]), 64'd2);
        wr(CLAIM1, 32'd6);
        settle();
        check("t1_complete", 64'(gw_state[6]), 64'd0);

        // Reset with a source in service and a read outstanding
        @(negedge clk);
        src[6] = 1'b1;
        settle();
        rd_chk("rst_claim6", CLAIM1, 32'd6);
        settle();
        check("rst_pre_gw", 64'(gw_state[6]), 64'd2);
        @(negedge clk);
        s_mem.req  = 1'b1;
        s_mem.we   = 1'b0;
        s_mem.addr = a_prio(6);
        s_mem.be   = 4'hF;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        s_mem.req = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(s_mem.valid), 64'd0);
        check("mid_rst_rdata", 64'(s_mem.rdata), 64'd0);
        check("mid_rst_error", 64'(s_mem.error), 64'd0);
        check("mid_rst_irq", 64'(irq), 64'd0);
        check("mid_rst_irq_id", 64'(irq_id), 64'd0);
        check("mid_rst_gw", 64'(gw_state), 64'd0);
        src[6] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 64'(s_mem.valid), 64'd0);
        rd_chk("post_rst_prio6", a_prio(6), 32'd0);
        rd_chk("post_rst_en1", EN1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
